ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED to set LEDs, or 0xFF to reset) from the FPGA to the keyboard over the same key_clk/key_data lines that the keyboard1 receiver listens on.
- It drives both lines open-drain through pull-low enables. The keyboard generates the clock.
- The top level ties the lines as key_clk = key_clk_oe ? 0 : Z, and the same for key_data.
- While host_busy is high, the receiver must ignore frames.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter states, error codes and common
// keyboard command bytes. The keyboard receiver imports the same package.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE,
    S_ERR
  } ps2_tx_state_e;

  localparam logic [1:0] E_NONE     = 2'b00;
  localparam logic [1:0] E_START_TO = 2'b01;
  localparam logic [1:0] E_XFER_TO  = 2'b10;
  localparam logic [1:0] E_NO_ACK   = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge detector
// on the synchronised level.
module ps2_sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Flops reset to 1, the pulled-up idle level, so leaving reset never fakes an edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts out one command byte on device-generated clock falls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 12000,
  parameter int START_TO_CYC = 1500000,
  parameter int XFER_TO_CYC  = 200000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       key_clk_in,
  input  logic       key_data_in,
  output logic       key_clk_oe,
  output logic       key_data_oe,
  output logic       host_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int TMR_MAX0 = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
  localparam int TMR_MAX  = (TMR_MAX0 > XFER_TO_CYC) ? TMR_MAX0 : XFER_TO_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_TO_CYC - 1);
  localparam logic [TMR_W-1:0] XFER_LOAD    = TMR_W'(XFER_TO_CYC - 1);

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk_in (clk_in),
    .rst    (rst),
    .line_in(key_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk_in (clk_in),
    .rst    (rst),
    .line_in(key_data_in),
    .level  (data_level),
    .fall   (data_fall_unused)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             tmo, fail;
  logic [1:0]       fail_code;

  assign tmo = (tmr_q == '0);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d    = state_q;
    tmr_d      = tmo ? tmr_q : tmr_q - TMR_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = E_NONE;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          tmr_d     = INHIBIT_LOAD;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // Start bit goes low during the final inhibit cycle, before the clock is released.
        if (tmo) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          tmr_d     = START_LOAD;
          state_d   = S_REQ;
        end else if (tmr_q == TMR_W'(1)) begin
          data_oe_d = 1'b1;
        end
      end
      S_REQ: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_START_TO;
        end else if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          bit_cnt_d = 4'd1;
          tmr_d     = XFER_LOAD;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_XFER_TO;
        end else if (clk_fall) begin
          data_oe_d = ~shift_q[bit_cnt_q];
          if (bit_cnt_q == 4'd8) state_d = S_STOP;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_STOP: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_XFER_TO;
        end else if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_XFER_TO;
        end else if (clk_fall) begin
          if (!data_level) begin
            state_d = S_WAIT_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = E_NO_ACK;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = E_XFER_TO;
        end else if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fail) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      err_code_d = fail_code;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign host_busy   = (state_q != S_IDLE);
  assign key_clk_oe  = clk_oe_q;
  assign key_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device generates the clock,
// samples the host frame and answers with (or withholds) the ack.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT  = 40;
  localparam int START_TO = 500;
  localparam int XFER_TO  = 2000;
  localparam int HALF     = 20;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, key_clk_oe, key_data_oe, host_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       dev_clk, dev_data;
  logic       key_clk_in, key_data_in;

  // Open-drain bus: a line is high only when nobody pulls it low.
  assign key_clk_in  = dev_clk & ~key_clk_oe;
  assign key_data_in = dev_data & ~key_data_oe;

  always #5 clk_in = ~clk_in;

  ps2_host_tx #(
    .INHIBIT_CYC (INHIBIT),
    .START_TO_CYC(START_TO),
    .XFER_TO_CYC (XFER_TO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .key_clk_in (key_clk_in),
    .key_data_in(key_data_in),
    .key_clk_oe (key_clk_oe),
    .key_data_oe(key_data_oe),
    .host_busy  (host_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code)
  );

  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, inhibit_cnt = 0;
  int         oe_run = 0, last_oe_run = 0, release_cyc = 0, err_cyc = 0;
  bit         data_early = 1'b0, last_data_early = 1'b0;
  logic [1:0] err_code_seen = 2'b00;
  logic [1:0] err_oe_seen = 2'b00;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt       <= err_cnt + 1;
      err_cyc       <= cyc;
      err_code_seen <= err_code;
      err_oe_seen   <= {key_clk_oe, key_data_oe};
    end
    if (key_clk_oe) begin
      oe_run     <= oe_run + 1;
      data_early <= (oe_run == 0) ? key_data_oe : (data_early | key_data_oe);
      if (oe_run == 0) inhibit_cnt <= inhibit_cnt + 1;
    end else if (oe_run != 0) begin
      last_oe_run     <= oe_run;
      last_data_early <= data_early;
      release_cyc     <= cyc;
      oe_run          <= 0;
    end
  end

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it on the wire: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] data;
    int         n_falls;
    bit         ack;
    bit         exp_done;
    logic [1:0] exp_code;
    bit         exp_parity;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] model_code = E_NONE;

  task automatic wait_clk_oe(input logic val, input int bound);
    for (int i = 0; i < bound && key_clk_oe !== val; i++) @(negedge clk_in);
  endtask

  task automatic wait_outcome(input int d0, input int e0, input int bound);
    for (int i = 0; i < bound && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk_in);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    wait_clk_oe(1'b1, 10);
    wait_clk_oe(1'b0, INHIBIT + 20);
  endtask

  // Device side: clock n_falls falls, sampling data at the end of each high phase.
  task automatic dev_frame(input int n_falls, input bit ack, output logic [10:0] line);
    line = '1;
    for (int k = 0; k < n_falls; k++) begin
      repeat (HALF) @(negedge clk_in);
      line[k] = key_data_in;
      if (k == 10 && ack) begin
        dev_data = 1'b0;
        repeat (4) @(negedge clk_in);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_in);
      dev_clk = 1'b1;
    end
    repeat (4) @(negedge clk_in);
    dev_data = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int          d0, e0;
    logic [10:0] line;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(v.data);
    dev_frame(v.n_falls, v.ack, line);
    wait_outcome(d0, e0, XFER_TO + 500);
    check($sformatf("%s_inhibit_len", tag), 32'(last_oe_run), 32'(INHIBIT));
    check($sformatf("%s_data_before_clk", tag), 32'(last_data_early), 32'd1);
    if (v.n_falls == 11) begin
      check($sformatf("%s_frame", tag), 32'(line), 32'(ref_frame(v.data)));
      check($sformatf("%s_parity", tag), 32'(line[9]), 32'(v.exp_parity));
    end
    check($sformatf("%s_done", tag), 32'(done_cnt - d0), 32'(v.exp_done));
    check($sformatf("%s_err", tag), 32'(err_cnt - e0), 32'(!v.exp_done));
    if (!v.exp_done) begin
      check($sformatf("%s_err_code_at_pulse", tag), 32'(err_code_seen), 32'(v.exp_code));
      check($sformatf("%s_oe_at_err", tag), 32'(err_oe_seen), 32'd0);
    end
    check($sformatf("%s_err_code", tag), 32'(err_code), 32'(v.exp_code));
    check($sformatf("%s_released", tag), 32'({key_clk_oe, key_data_oe}), 32'd0);
    check($sformatf("%s_ready", tag), 32'(tx_ready), 32'd1);
  endtask

  initial begin
    int          d0, e0, i0;
    logic [10:0] line;
    vec_t        rv;

    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    vecs[0] = '{CMD_SET_LED, 11, 1'b1, 1'b1, E_NONE,   1'b1};
    vecs[1] = '{8'h00,       11, 1'b1, 1'b1, E_NONE,   1'b1};
    vecs[2] = '{8'hFF,       11, 1'b1, 1'b1, E_NONE,   1'b1};
    vecs[3] = '{8'h07,       11, 1'b1, 1'b1, E_NONE,   1'b0};
    vecs[4] = '{8'h3C,       11, 1'b0, 1'b0, E_NO_ACK, 1'b1};
    vecs[5] = '{CMD_RESET,   11, 1'b1, 1'b1, E_NO_ACK, 1'b1};
    vecs[6] = '{8'hA5,        5, 1'b1, 1'b0, E_XFER_TO, 1'b1};

    repeat (3) @(negedge clk_in);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(host_busy), 32'd0);
    check("rst_oe", 32'({key_clk_oe, key_data_oe}), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'(E_NONE));
    rst = 1'b1;
    repeat (5) @(negedge clk_in);

    for (int i = 0; i < 7; i++) begin
      run_row(vecs[i], $sformatf("vec%0d", i));
      model_code = vecs[i].exp_code;
    end

    for (int i = 0; i < 8; i++) begin
      rv.data       = 8'($urandom);
      rv.n_falls    = 11;
      rv.ack        = 1'b1;
      rv.exp_done   = 1'b1;
      rv.exp_code   = model_code;
      rv.exp_parity = ($countones(rv.data) % 2 == 0);
      run_row(rv, $sformatf("rnd%0d_%02h", i, rv.data));
    end

    // Silent device: start timeout counted from the clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(CMD_SET_LED);
    wait_outcome(d0, e0, START_TO + 200);
    check("start_to_err", 32'(err_cnt - e0), 32'd1);
    check("start_to_done", 32'(done_cnt - d0), 32'd0);
    check("start_to_code", 32'(err_code_seen), 32'(E_START_TO));
    check("start_to_delay", 32'(err_cyc - release_cyc), 32'(START_TO));
    check("start_to_oe", 32'(err_oe_seen), 32'd0);
    check("start_to_ready", 32'(tx_ready), 32'd1);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h00);
    dev_frame(4, 1'b0, line);
    @(negedge clk_in);
    #2;
    check("mid_rst_pre_data_oe", 32'(key_data_oe), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_oe", 32'({key_clk_oe, key_data_oe}), 32'd0);
    repeat (3) @(negedge clk_in);
    check("mid_rst_ready_in_rst", 32'(tx_ready), 32'd1);
    rst = 1'b1;
    dev_frame(2, 1'b0, line);
    repeat (50) @(negedge clk_in);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("idle_fall_busy", 32'(host_busy), 32'd0);
    check("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'(E_NONE));

    // tx_valid during INHIBIT must not start or alter a frame.
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inhibit_cnt;
    @(negedge clk_in);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk_in);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk_in);
    tx_valid = 1'b0;
    wait_clk_oe(1'b0, INHIBIT + 20);
    dev_frame(11, 1'b1, line);
    wait_outcome(d0, e0, XFER_TO + 500);
    check("busy_frame", 32'(line), 32'(ref_frame(8'h5A)));
    check("busy_done", 32'(done_cnt - d0), 32'd1);
    repeat (200) @(negedge clk_in);
    check("busy_one_frame", 32'(inhibit_cnt - i0), 32'd1);
    check("busy_idle", 32'(host_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
